// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and helpers for the VGA timing core.
//   - standard mode timings (640x480@60, 800x600@60)
//   - RGB struct and width helper
//   - {R,G,B} on/off masks for the 8-bar test pattern
package vga_pkg;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 800x600@60, 40 MHz pixel clock, positive syncs
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  function automatic int rgb_width(input int color_w);
    return 3 * color_w;
  endfunction

  // Bar n uses BAR_MASKS[n] as {R,G,B}: white, yellow, cyan, green,
  // magenta, red, blue, black (element 0 is the rightmost literal).
  localparam logic [7:0][2:0] BAR_MASKS = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: WIDTH-bit shift register, DEPTH stages, synchronous
// active-high clear. DEPTH = 0 degenerates to a wire.
//   clk  in   clock
//   rst  in   clears every stage to 0
//   d    in   WIDTH data in
//   q    out  d delayed by DEPTH cycles
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q = d;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

    always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = d;
      for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk) begin
      if (rst) pipe_q <= '0;
      else     pipe_q <= pipe_d;
    end

    assign q = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_core.sv
// vga_timing_core: parametrised VGA raster generator and registered pin stage.
//   clk_vga      in   pixel clock
//   rst          in   synchronous reset, active high
//   pattern_sel  in   (VGA_TEST_PATTERN_EN only) replace vga_data by colour bars
//   vga_data     in   {R,G,B} for the pixel requested DATA_LAT cycles earlier
//   vga_request  out  counters in active area (request stage, combinational)
//   vga_xpos/ypos out coordinates of requested pixel, 0 when not requesting
//   frame_start  out  pulse at request-stage (0,0)
//   vga_hs/vs    out  registered syncs, active level HS_POL/VS_POL
//   vga_blank_n  out  registered, high in active video
//   vga_sync_n   out  constant 0
//   vga_rgb      out  registered pixel, zero outside active video
// Optional feature macro: VGA_TEST_PATTERN_EN (8 vertical colour bars).
// All pin outputs lag the request stage by DATA_LAT+1 cycles.
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 8,
  parameter int DATA_LAT = 1,
  parameter int CNT_W    = 12
) (
  input  logic                          clk_vga,
  input  logic                          rst,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                          pattern_sel,
`endif
  input  logic [rgb_width(COLOR_W)-1:0] vga_data,
  output logic                          vga_request,
  output logic [CNT_W-1:0]              vga_xpos,
  output logic [CNT_W-1:0]              vga_ypos,
  output logic                          frame_start,
  output logic                          vga_hs,
  output logic                          vga_vs,
  output logic                          vga_blank_n,
  output logic                          vga_sync_n,
  output logic [rgb_width(COLOR_W)-1:0] vga_rgb
);

  localparam int RGB_W = rgb_width(COLOR_W);

  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  // ---------------- raster counters ----------------
  logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;

  always_comb begin
    hc_d = hc_q + 1'b1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  // ---------------- request stage ----------------
  // Gated by rst so nothing is requested (and no sync enters the pipe)
  // while reset is held.
  logic act, hs_in, vs_in;
  assign act   = !rst && (hc_q < H_ACT) && (vc_q < V_ACT);
  assign hs_in = !rst && (hc_q >= H_SS) && (hc_q < H_SE);
  assign vs_in = !rst && (vc_q >= V_SS) && (vc_q < V_SE);

  assign vga_request = act;
  assign vga_xpos    = act ? hc_q : '0;
  assign vga_ypos    = act ? vc_q : '0;
  assign frame_start = !rst && (hc_q == '0) && (vc_q == '0);

  // ---------------- flag pipeline ----------------
  // Cleared by rst so in-flight flags of an interrupted line never reach pins.
  logic [2:0] flag_dl;
  logic       act_dl, hs_dl, vs_dl;

  vga_delay_line #(.WIDTH(3), .DEPTH(DATA_LAT)) u_flag_dl (
    .clk (clk_vga),
    .rst (rst),
    .d   ({act, hs_in, vs_in}),
    .q   (flag_dl)
  );
  assign {act_dl, hs_dl, vs_dl} = flag_dl;

  // ---------------- pixel source ----------------
  logic [RGB_W-1:0] pix;

`ifdef VGA_TEST_PATTERN_EN
  localparam int               BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [CNT_W-1:0] BAR_W_C = CNT_W'(BAR_W);

  logic [CNT_W-1:0] xpos_dl, bar_idx;
  logic [2:0]       mask;

  vga_delay_line #(.WIDTH(CNT_W), .DEPTH(DATA_LAT)) u_xpos_dl (
    .clk (clk_vga),
    .rst (rst),
    .d   (vga_xpos),
    .q   (xpos_dl)
  );

  always_comb begin
    bar_idx = xpos_dl / BAR_W_C;
    // a ragged right edge (H_ACTIVE not a multiple of 8) stays in the last bar
    mask    = (bar_idx > CNT_W'(7)) ? BAR_MASKS[7] : BAR_MASKS[bar_idx[2:0]];
    pix     = pattern_sel ? {{COLOR_W{mask[2]}}, {COLOR_W{mask[1]}}, {COLOR_W{mask[0]}}}
                          : vga_data;
  end
`else
  assign pix = vga_data;
`endif

  // ---------------- output register ----------------
  logic             hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;

  always_comb begin
    hs_d      = hs_dl ? HS_POL : !HS_POL;
    vs_d      = vs_dl ? VS_POL : !VS_POL;
    blank_n_d = act_dl;
    rgb_d     = act_dl ? pix : '0;
  end

  always_ff @(posedge clk_vga) begin
    if (rst) begin
      hs_q      <= !HS_POL;
      vs_q      <= !VS_POL;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
    end
  end

  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_rgb     = rgb_q;
  assign vga_sync_n  = 1'b0;

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core: two small-raster instances (DATA_LAT=3 with
// positive hsync, DATA_LAT=0 with positive vsync) driven with random pixel
// data and random reset pulses. Expected values come from a raster model
// that maps "cycles since reset release" to (x,y) with plain arithmetic.
module tb_vga_timing_core;

  localparam int MAXC = 3000;

  logic clk_vga = 1'b0;
  always #5 clk_vga = ~clk_vga;

  logic rst;
`ifdef VGA_TEST_PATTERN_EN
  logic pattern_sel;
`endif

  // instance A: 23x10 raster, DATA_LAT=3, 4-bit colour
  logic [11:0] a_data, a_rgb;
  logic [5:0]  a_x, a_y;
  logic        a_req, a_fs, a_hs, a_vs, a_bn, a_sn;
  // instance B: 12x8 raster, DATA_LAT=0, 2-bit colour
  logic [5:0]  b_data, b_rgb;
  logic [4:0]  b_x, b_y;
  logic        b_req, b_fs, b_hs, b_vs, b_bn, b_sn;

  vga_timing_core #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .COLOR_W(4), .DATA_LAT(3), .CNT_W(6)
  ) u_dut_a (
    .clk_vga(clk_vga), .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .vga_data(a_data), .vga_request(a_req), .vga_xpos(a_x), .vga_ypos(a_y),
    .frame_start(a_fs), .vga_hs(a_hs), .vga_vs(a_vs), .vga_blank_n(a_bn),
    .vga_sync_n(a_sn), .vga_rgb(a_rgb)
  );

  vga_timing_core #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b1), .COLOR_W(2), .DATA_LAT(0), .CNT_W(5)
  ) u_dut_b (
    .clk_vga(clk_vga), .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .vga_data(b_data), .vga_request(b_req), .vga_xpos(b_x), .vga_ypos(b_y),
    .frame_start(b_fs), .vga_hs(b_hs), .vga_vs(b_vs), .vga_blank_n(b_bn),
    .vga_sync_n(b_sn), .vga_rgb(b_rgb)
  );

  // ---------------- model configuration ----------------
  int ha[2]   = '{16, 8};
  int hf[2]   = '{2, 1};
  int hsw[2]  = '{3, 2};
  int hb[2]   = '{2, 1};
  int va[2]   = '{6, 4};
  int vf[2]   = '{1, 1};
  int vsw[2]  = '{2, 1};
  int vb[2]   = '{1, 2};
  int lat[2]  = '{3, 0};
  int cw[2]   = '{4, 2};
  bit hpol[2] = '{1'b1, 1'b0};
  bit vpol[2] = '{1'b0, 1'b1};

  // history, indexed by cycle
  bit          rst_h [MAXC];
  bit          pat_h [MAXC];
  int          pos_h [2][MAXC];
  logic [31:0] dat_h [2][MAXC];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int htot(input int id);
    return ha[id] + hf[id] + hsw[id] + hb[id];
  endfunction

  function automatic int ftot(input int id);
    return htot(id) * (va[id] + vf[id] + vsw[id] + vb[id]);
  endfunction

`ifdef VGA_TEST_PATTERN_EN
  bit [2:0] bar_tab[8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

  function automatic logic [31:0] bar_rgb(input int id, input int x);
    int bw, idx;
    logic [31:0] ones;
    bit [2:0] m;
    bw   = (ha[id] / 8 > 0) ? ha[id] / 8 : 1;
    idx  = x / bw;
    if (idx > 7) idx = 7;
    m    = bar_tab[idx];
    ones = (32'd1 << cw[id]) - 32'd1;
    return ((m[2] ? ones : 32'd0) << (2 * cw[id])) |
           ((m[1] ? ones : 32'd0) << cw[id]) | (m[0] ? ones : 32'd0);
  endfunction
`endif

  task automatic chk_inst(input int id, input int n, input logic req,
                          input logic [31:0] xp, input logic [31:0] yp, input logic fs,
                          input logic hs, input logic vs, input logic bn, input logic sn,
                          input logic [31:0] rgb);
    string p;
    int pos, x, y, t, tx, ty;
    bit e_req, win, e_hs, e_vs, e_bn;
    logic [31:0] e_rgb;
    p     = $sformatf("%s@%0d", (id == 0) ? "A" : "B", n);
    pos   = pos_h[id][n];
    x     = pos % htot(id);
    y     = pos / htot(id);
    e_req = !rst_h[n] && x < ha[id] && y < va[id];
    chk({p, ".req"},   64'(req), 64'(e_req));
    chk({p, ".xpos"},  64'(xp),  e_req ? 64'(x) : 64'd0);
    chk({p, ".ypos"},  64'(yp),  e_req ? 64'(y) : 64'd0);
    chk({p, ".fs"},    64'(fs),  64'(!rst_h[n] && pos == 0));
    chk({p, ".syncn"}, 64'(sn),  64'd0);

    // any reset inside the latency window leaves the pins inactive
    win = 1'b0;
    for (int j = n - 1 - lat[id]; j <= n - 1; j++)
      if (j < 0 || rst_h[j]) win = 1'b1;
    if (win) begin
      e_hs = !hpol[id]; e_vs = !vpol[id]; e_bn = 1'b0; e_rgb = '0;
    end else begin
      t     = n - 1 - lat[id];
      tx    = pos_h[id][t] % htot(id);
      ty    = pos_h[id][t] / htot(id);
      e_bn  = tx < ha[id] && ty < va[id];
      e_hs  = (tx >= ha[id] + hf[id] && tx < ha[id] + hf[id] + hsw[id]) ? hpol[id] : !hpol[id];
      e_vs  = (ty >= va[id] + vf[id] && ty < va[id] + vf[id] + vsw[id]) ? vpol[id] : !vpol[id];
      e_rgb = e_bn ? dat_h[id][n-1] : '0;
`ifdef VGA_TEST_PATTERN_EN
      if (e_bn && pat_h[n-1]) e_rgb = bar_rgb(id, tx);
`endif
    end
    chk({p, ".hs"},     64'(hs),  64'(e_hs));
    chk({p, ".vs"},     64'(vs),  64'(e_vs));
    chk({p, ".blankn"}, 64'(bn),  64'(e_bn));
    chk({p, ".rgb"},    64'(rgb), 64'(e_rgb));
  endtask

  initial begin
    int rlen;
    bit r;
    rlen   = 0;
    rst    = 1'b1;
    a_data = '0;
    b_data = '0;
`ifdef VGA_TEST_PATTERN_EN
    pattern_sel = 1'b0;
`endif
    for (int n = 0; n < MAXC; n++) begin
      @(posedge clk_vga);
      #1;
      // 5-cycle power-on reset, clean frames, then forced and random pulses
      if (n < 5) r = 1'b1;
      else if (rlen > 0) begin r = 1'b1; rlen--; end
      else if (n == 1207 || n == 1850) begin r = 1'b1; rlen = 0; end
      else if (n > 1300 && $urandom_range(0, 499) == 0) begin
        r = 1'b1; rlen = $urandom_range(0, 2);
      end else r = 1'b0;
      rst    = r;
      a_data = 12'($urandom);
      b_data = 6'($urandom);
`ifdef VGA_TEST_PATTERN_EN
      if (n % 97 == 0) pattern_sel = 1'($urandom_range(0, 1));
      pat_h[n] = pattern_sel;
`else
      pat_h[n] = 1'b0;
`endif
      rst_h[n]    = r;
      dat_h[0][n] = 32'(a_data);
      dat_h[1][n] = 32'(b_data);
      for (int id = 0; id < 2; id++)
        pos_h[id][n] = (n == 0 || rst_h[n-1]) ? 0 : (pos_h[id][n-1] + 1) % ftot(id);

      @(negedge clk_vga);
      if (n >= 1) begin
        chk_inst(0, n, a_req, 32'(a_x), 32'(a_y), a_fs, a_hs, a_vs, a_bn, a_sn, 32'(a_rgb));
        chk_inst(1, n, b_req, 32'(b_x), 32'(b_y), b_fs, b_hs, b_vs, b_bn, b_sn, 32'(b_rgb));
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_core.md
# vga_timing_core

Parametrised VGA timing generator and pixel output stage; next generation of the fixed 640x480 driver. Generates raster counters, pixel requests with a configurable lead for upstream sources of known latency, and registered sync/blank/RGB outputs for the video DAC. Sits between the pixel clock domain's display/frame logic (upstream, `vga_data`) and the board pins (downstream). All timing, polarity and colour width are set by parameters.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal porch/sync widths in pixels
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch/sync widths in lines
- `HS_POL` / `VS_POL`, 0 / 0, active level of hsync / vsync
- `COLOR_W`, 8, bits per colour channel
- `DATA_LAT`, 1, upstream latency in cycles from request to `vga_data` valid; legal 0..4
- `CNT_W`, 12, counter / position width; must hold H_TOTAL-1 and V_TOTAL-1
- `clk_vga`  in  1  pixel clock
- `rst`  in  1  synchronous reset, active-high
- `vga_data`  in  3*COLOR_W  {R,G,B} for the pixel requested DATA_LAT cycles earlier
- `vga_request`  out  1  pixel request, high while counters are in the active area
- `vga_xpos` / `vga_ypos`  out  CNT_W  coordinates of the requested pixel; 0 when not requesting
- `frame_start`  out  1  one-cycle pulse at request-stage (0,0)
- `vga_hs` / `vga_vs`  out  1  sync outputs, polarity per HS_POL/VS_POL
- `vga_blank_n`  out  1  high during active video
- `vga_sync_n`  out  1  constant 0 (no sync-on-green)
- `vga_rgb`  out  3*COLOR_W  pixel data, zero outside active video

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL analogous; widths computed at CNT_W.
- `hc` counts 0..H_TOTAL-1, wraps to 0; `vc` increments on `hc` wrap, wraps V_TOTAL-1 -> 0 on simultaneous h and v wrap.
- Origin is first active pixel: active when `hc`<H_ACTIVE and `vc`<V_ACTIVE.
- Sync region: H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (likewise vertical, in lines); vsync changes on hc=0 boundary.
- Request stage (cycle t): `vga_request`, `vga_xpos`, `vga_ypos`, `frame_start` combinational from counters.
- Timing flags (active, hs, vs) pass through a DATA_LAT-deep shift register plus one output register.
- Output stage: `vga_rgb` = delayed-active ? `vga_data` : 0, registered together with `vga_hs`, `vga_vs`, `vga_blank_n`.
- Reset: hc=vc=0, flag pipeline cleared to inactive; outputs `vga_hs`=!HS_POL, `vga_vs`=!VS_POL, `vga_blank_n`=0, `vga_rgb`=0, `vga_sync_n`=0. Request-stage outputs 0 while `rst` high.
- Reset mid-frame: counters restart at (0,0) the cycle after `rst` deasserts; in-flight pipeline flags discarded; no partial line emitted.

## Timing
- Request at cycle t -> upstream data sampled at t+DATA_LAT -> pins at t+DATA_LAT+1.
- All pin outputs registered; total latency DATA_LAT+1 for every output, so sync/blank/rgb stay mutually aligned.
- First request after reset release: cycle 0 after `rst` low, `frame_start`=1, xpos=ypos=0.
- DATA_LAT=0: `vga_data` is sampled the same cycle as the request (combinational upstream).
- Throughput: one pixel per clock, no stalls; upstream has no back-pressure.

## Configuration
- `VGA_TEST_PATTERN_EN` defined: adds input `pattern_sel` (1 bit); when high, output stage replaces `vga_data` with 8 vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black), each H_ACTIVE/8 pixels wide, from delayed xpos; timing unchanged; bar colour channels all-ones or zero.
- Not defined: no `pattern_sel` port; output is always `vga_data`.

## Structure
- Shared package `vga_pkg`: resolution constants for 640x480@60 and 800x600@60, RGB struct/width helpers, bar colour table.
- One sub-module `vga_delay_line` (parametrised width/depth shift register, depth 0 = wire) used for flag and xpos pipelines.

## Test plan
- Reset held 5 cycles -> hs=vs=1 (POL 0), blank_n=0, rgb=0, sync_n=0; first cycle after release request=1, xpos=0, frame_start=1.
- Default 640x480, DATA_LAT=1: vga_hs low from output cycle 656+2 to 751+2 of each line; blank_n high exactly 640 cycles per line.
- DATA_LAT=3 with upstream model returning {xpos,ypos} delayed 3 cycles -> every active pin pixel equals its own coordinates; rgb=0 in blanking.
- Run to vc=524, hc=799 -> next cycle hc=vc=0, frame_start=1; frame period 420000 cycles.
- 800x600 parameters (40/128/88, 1/4/23, POL 1) -> hs high 128 cycles, period 1056; vs high 4 lines, frame 628 lines.
- `VGA_TEST_PATTERN_EN`, pattern_sel=1 -> pixel 79 white, pixel 80 yellow (R,G all-ones, B 0), pixel 639 black; rst asserted mid-line -> outputs inactive next cycle, restart at (0,0).
